md_unit_ex: RTL and testbench

- Multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded MD operation and the forwarded RS_E/RT_E operands.
- Runs MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations into HI/LO, and services MTHI/MTLO in one cycle.
- Exposes busy so the D-stage hazard logic can stall the ID/EX register.

---
 rtl/md_unit_ex_if.sv | 14 +
 rtl/md_unit_ex.sv | 119 +++++++++++
 tb/tb_md_unit_ex.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/md_unit_ex_if.sv
// Operand/result bundle between the EX-stage issue logic and the multiply/divide unit.
// The master drives the decoded operation and operands; the slave returns busy and HI/LO.
interface md_unit_ex_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, md_op, A, B, input busy, HI, LO);
  modport slave  (input start, md_op, A, B, output busy, HI, LO);
endinterface

// File: rtl/md_unit_ex.sv
// EX-stage multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU into HI/LO,
// single-cycle MTHI/MTLO, and a busy flag for the D-stage stall logic.
module md_unit_ex #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  md_unit_ex_if.slave  md
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;
  logic [31:0] r_hi_p, w_hi_p_nxt;
  logic [31:0] r_lo_p, w_lo_p_nxt;
  logic        r_wr_p, w_wr_p_nxt;

  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_a_mag, w_b_mag, w_b_mag_safe, w_b_safe;
  logic [31:0] w_qs_mag, w_rs_mag, w_qs, w_rs, w_qu, w_ru;

  // Sign-extending to 64 bits makes the low 64 bits of an unsigned product the signed product.
  assign w_prod_s = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
  assign w_prod_u = {32'd0, md.A} * {32'd0, md.B};

  // Signed divide via magnitudes; 0x80000000 / -1 then wraps to 0x80000000 with no special case.
  assign w_a_mag      = md.A[31] ? -md.A : md.A;
  assign w_b_mag      = md.B[31] ? -md.B : md.B;
  assign w_b_mag_safe = (md.B == 32'd0) ? 32'd1 : w_b_mag;
  assign w_b_safe     = (md.B == 32'd0) ? 32'd1 : md.B;
  assign w_qs_mag     = w_a_mag / w_b_mag_safe;
  assign w_rs_mag     = w_a_mag % w_b_mag_safe;
  assign w_qs         = (md.A[31] ^ md.B[31]) ? -w_qs_mag : w_qs_mag;
  assign w_rs         = md.A[31] ? -w_rs_mag : w_rs_mag;
  assign w_qu         = md.A / w_b_safe;
  assign w_ru         = md.A % w_b_safe;

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_hi_p_nxt  = r_hi_p;
    w_lo_p_nxt  = r_lo_p;
    w_wr_p_nxt  = r_wr_p;

    unique case (r_state)
      S_IDLE: begin
        if (md.start) begin
          unique case (md.md_op)
            3'd0, 3'd1: begin
              w_hi_p_nxt  = (md.md_op == 3'd0) ? w_prod_s[63:32] : w_prod_u[63:32];
              w_lo_p_nxt  = (md.md_op == 3'd0) ? w_prod_s[31:0]  : w_prod_u[31:0];
              w_wr_p_nxt  = 1'b1;
              w_cnt_nxt   = MULT_LAT;
              w_state_nxt = S_RUN;
            end
            3'd2, 3'd3: begin
              w_hi_p_nxt  = (md.md_op == 3'd2) ? w_rs : w_ru;
              w_lo_p_nxt  = (md.md_op == 3'd2) ? w_qs : w_qu;
              // Divide by zero still runs full latency but leaves HI/LO untouched.
              w_wr_p_nxt  = (md.B != 32'd0);
              w_cnt_nxt   = DIV_LAT;
              w_state_nxt = S_RUN;
            end
            3'd4:    w_hi_nxt = md.A;
            3'd5:    w_lo_nxt = md.A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_IDLE;
          if (r_wr_p) begin
            w_hi_nxt = r_hi_p;
            w_lo_nxt = r_lo_p;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_hi_p  <= 32'd0;
      r_lo_p  <= 32'd0;
      r_wr_p  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_hi_p  <= w_hi_p_nxt;
      r_lo_p  <= w_lo_p_nxt;
      r_wr_p  <= w_wr_p_nxt;
    end
  end

  assign md.busy = (r_state == S_RUN);
  assign md.HI   = r_hi;
  assign md.LO   = r_lo;

endmodule

// File: tb/tb_md_unit_ex.sv
// Directed bench for md_unit_ex: MD results flow through a scoreboard queue,
// single-cycle moves, ignored starts and asynchronous reset are checked inline.
module tb_md_unit_ex;

  logic clk;
  logic rst_n;
  md_unit_ex_if bus ();

  md_unit_ex #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_and_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_hi"}, bus.HI, e.hi);
      check({e.tag, "_lo"}, bus.LO, e.lo);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  // Issue one multi-cycle op, scramble operands after acceptance, measure busy width.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    exp_t e;
    int   n;
    e.tag = tag; e.hi = eh; e.lo = el; e.lat = lat;
    sb.push_back(e);
    bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.B = b;
    tick();
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    check({tag, "_hold_hi"}, bus.HI, m_hi);
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(lat));
    pop_and_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.md_op = 3'd0; bus.A = 32'd0; bus.B = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_hi", bus.HI, 32'd0);
    check("reset_lo", bus.LO, 32'd0);

    // MTHI then MTLO back to back
    bus.start = 1'b1; bus.md_op = 3'd4; bus.A = 32'hDEADBEEF;
    tick();
    check("mthi_hi", bus.HI, 32'hDEADBEEF);
    check("mthi_lo", bus.LO, 32'd0);
    check("mthi_busy", 32'(bus.busy), 32'd0);
    bus.md_op = 3'd5; bus.A = 32'hCAFEF00D;
    tick();
    bus.start = 1'b0;
    check("mtlo_lo", bus.LO, 32'hCAFEF00D);
    check("mtlo_hi", bus.HI, 32'hDEADBEEF);
    check("mtlo_busy", 32'(bus.busy), 32'd0);
    m_hi = 32'hDEADBEEF; m_lo = 32'hCAFEF00D;

    run_md("mult_neg",  3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    run_md("multu",     3'd1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
    run_md("mult_max",  3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5);
    run_md("div_neg",   3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_md("div_negb",  3'd2, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10);
    run_md("divu",      3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10);
    run_md("div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);

    // Reserved opcode does nothing
    bus.start = 1'b1; bus.md_op = 3'd6; bus.A = 32'h55555555;
    tick();
    bus.start = 1'b0;
    check("rsvd_busy", 32'(bus.busy), 32'd0);
    check("rsvd_hi", bus.HI, m_hi);
    check("rsvd_lo", bus.LO, m_lo);

    // Divide by zero with HI preset
    bus.start = 1'b1; bus.md_op = 3'd4; bus.A = 32'h12345678;
    tick();
    bus.start = 1'b0;
    m_hi = 32'h12345678;
    check("preset_hi", bus.HI, m_hi);
    run_md("divu_by0", 3'd3, 32'd5, 32'd0, m_hi, m_lo, 10);
    run_md("div_by0",  3'd2, 32'hFFFFFFF0, 32'd0, m_hi, m_lo, 10);

    // Starts while busy (including the falling-busy cycle) are ignored
    begin
      exp_t e;
      e.tag = "mult_ign"; e.hi = 32'd0; e.lo = 32'd15; e.lat = 5;
      sb.push_back(e);
      bus.start = 1'b1; bus.md_op = 3'd0; bus.A = 32'd3; bus.B = 32'd5;
      tick();
      bus.start = 1'b0;
      check("ign_busy_e0", 32'(bus.busy), 32'd1);
      tick();
      bus.start = 1'b1; bus.md_op = 3'd5; bus.A = 32'h1;
      tick();
      bus.md_op = 3'd2; bus.A = 32'd100; bus.B = 32'd7;
      tick();
      bus.start = 1'b0;
      check("ign_lo_mid", bus.LO, m_lo);
      tick();
      check("ign_busy_e4", 32'(bus.busy), 32'd1);
      bus.start = 1'b1; bus.md_op = 3'd4; bus.A = 32'h00000BAD;
      tick();
      bus.start = 1'b0;
      check("ign_busy_e5", 32'(bus.busy), 32'd0);
      pop_and_check("mult_ign");
      tick();
      check("ign_busy_e6", 32'(bus.busy), 32'd0);
      check("ign_hi_e6", bus.HI, m_hi);
      check("ign_lo_e6", bus.LO, m_lo);
    end

    // Asynchronous reset in the middle of a DIV
    bus.start = 1'b1; bus.md_op = 3'd2; bus.A = 32'd100; bus.B = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    check("rst_mid_busy_pre", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_hi", bus.HI, 32'd0);
    check("rst_mid_lo", bus.LO, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("post_rst_busy_%0d", i), 32'(bus.busy), 32'd0);
      check($sformatf("post_rst_hi_%0d", i), bus.HI, 32'd0);
      check($sformatf("post_rst_lo_%0d", i), bus.LO, 32'd0);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
